fdc_disk_sequencer: RTL

- Services the FDC's disk request/acknowledge channel: decodes the 32-bit request word `disk_sr` and sequences one disk operation at a time to the host-side storage agent (SD/MCU).
- Operations: seek, read-ID, read sector, write sector.
- Streams sector bytes between the host and the FDC byte FIFOs, then returns completion and status in `disk_cr`.
- Sits between the FDC core and the host disk-image agent.

---
 rtl/fdc_disk_sequencer_if.sv | 35 +++
 rtl/fdc_disk_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_disk_sequencer_if.sv
// Host-side disk agent channel of the FDC disk sequencer: command phase
// (req/ack with status) plus the read and write byte streams.
// master = sequencer, slave = host storage agent.
interface fdc_disk_sequencer_if;
    logic       host_req;
    logic [1:0] host_op;
    logic       host_drive;
    logic [6:0] host_cyl;
    logic [7:0] host_head;
    logic [7:0] host_sect;
    logic       host_ack;
    logic       host_err;
    logic       host_wp;
    logic [7:0] host_sectid;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       host_rready;
    logic [7:0] host_wdata;
    logic       host_wvalid;
    logic       host_wready;

    modport master (
        output host_req, host_op, host_drive, host_cyl, host_head, host_sect,
        output host_rready, host_wdata, host_wvalid,
        input  host_ack, host_err, host_wp, host_sectid,
        input  host_rdata, host_rvalid, host_wready
    );

    modport slave (
        input  host_req, host_op, host_drive, host_cyl, host_head, host_sect,
        input  host_rready, host_wdata, host_wvalid,
        output host_ack, host_err, host_wp, host_sectid,
        output host_rdata, host_rvalid, host_wready
    );
endinterface

// File: rtl/fdc_disk_sequencer.sv
// FDC disk sequencer: decodes the FDC request word, runs one seek / read-ID /
// read-sector / write-sector operation at a time against the host agent,
// streams sector bytes between host and FDC FIFOs and reports completion.
// Optional host watchdog enabled by defining FDC_SEQ_TIMEOUT_EN.
module fdc_disk_sequencer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned CNT_W          = 10,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          disk_sr,
    output logic [31:0]          disk_cr,
    output logic [7:0]           disk_data_in,
    output logic                 disk_data_clkin,
    input  logic [7:0]           disk_data_out,
    output logic                 disk_data_clkout,
    input  logic [1:0]           disk_present,
    fdc_disk_sequencer_if.master host
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RDSTREAM, S_WRSTREAM, S_WAITEND, S_DONE, S_RELEASE
    } state_t;

    // Per-byte sub-phase of a write: FIFO strobe, data capture, host handshake.
    typedef enum logic [1:0] {W_STROBE, W_CAPT, W_HOLD} wphase_t;

    typedef enum logic [1:0] {OP_SEEK, OP_READID, OP_READ, OP_WRITE} op_t;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(SECTOR_BYTES - 1);

    state_t           state_q, state_d;
    wphase_t          wphase_q, wphase_d;
    op_t              op_q, op_d;
    logic             drv_q, drv_d;
    logic [6:0]       cyl_q, cyl_d;
    logic [7:0]       head_q, head_d;
    logic [7:0]       sect_q, sect_d;
    logic             err_q, err_d;
    logic             wp_q, wp_d;
    logic [7:0]       sectid_q, sectid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wvalid_q, wvalid_d;
    logic [7:0]       din_q, din_d;
    logic             clkin_q, clkin_d;
    logic [7:0]       cr_sect_q, cr_sect_d;
    logic [7:0]       cr_head_q, cr_head_d;
    logic             cr_done_q, cr_done_d;
    logic             cr_err_q, cr_err_d;
    logic             cr_wp_q, cr_wp_d;
    logic [1:0]       cr_seek_q, cr_seek_d;

    op_t              pick_op;
    logic             pick_drv;
    logic             timeout;

`ifdef FDC_SEQ_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        watched;
    logic        byte_hs;

    assign watched = (state_q == S_REQ) || (state_q == S_RDSTREAM) ||
                     (state_q == S_WRSTREAM) || (state_q == S_WAITEND);
    assign byte_hs = ((state_q == S_RDSTREAM) && host.host_rvalid) ||
                     ((state_q == S_WRSTREAM) && (wphase_q == W_HOLD) && host.host_wready);
    assign timeout = watched && (wd_q >= (TIMEOUT_CYCLES - 24'd1));

    // Watchdog: restarts on every state entry and byte handshake.
    always_comb begin
        wd_d = watched ? (wd_q + 24'd1) : '0;
        if ((state_d != state_q) || byte_hs) wd_d = '0;
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Fixed-priority request pick: seek > readid > readsect > write, drive 0 first.
    always_comb begin
        pick_op  = OP_SEEK;
        pick_drv = 1'b0;
        if      (disk_sr[30]) begin pick_op = OP_SEEK;   pick_drv = 1'b0; end
        else if (disk_sr[31]) begin pick_op = OP_SEEK;   pick_drv = 1'b1; end
        else if (disk_sr[28]) begin pick_op = OP_READID; pick_drv = 1'b0; end
        else if (disk_sr[29]) begin pick_op = OP_READID; pick_drv = 1'b1; end
        else if (disk_sr[24]) begin pick_op = OP_READ;   pick_drv = 1'b0; end
        else if (disk_sr[25]) begin pick_op = OP_READ;   pick_drv = 1'b1; end
        else if (disk_sr[26]) begin pick_op = OP_WRITE;  pick_drv = 1'b0; end
        else if (disk_sr[27]) begin pick_op = OP_WRITE;  pick_drv = 1'b1; end
    end

    // Next-state and datapath updates for the operation sequencer.
    always_comb begin
        state_d   = state_q;
        wphase_d  = wphase_q;
        op_d      = op_q;
        drv_d     = drv_q;
        cyl_d     = cyl_q;
        head_d    = head_q;
        sect_d    = sect_q;
        err_d     = err_q;
        wp_d      = wp_q;
        sectid_d  = sectid_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        wvalid_d  = wvalid_q;
        din_d     = din_q;
        clkin_d   = 1'b0;
        cr_sect_d = cr_sect_q;
        cr_head_d = cr_head_q;
        cr_done_d = cr_done_q;
        cr_err_d  = cr_err_q;
        cr_wp_d   = cr_wp_q;
        cr_seek_d = cr_seek_q;

        case (state_q)
            S_IDLE: begin
                if (!disk_sr[23] && (|disk_sr[31:24])) begin
                    op_d     = pick_op;
                    drv_d    = pick_drv;
                    head_d   = disk_sr[22:15];
                    cyl_d    = disk_sr[14:8];
                    sect_d   = disk_sr[7:0];
                    err_d    = 1'b0;
                    wp_d     = 1'b0;
                    sectid_d = '0;
                    if (disk_present[pick_drv]) begin
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_REQ: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (host.host_ack) begin
                    err_d    = host.host_err;
                    wp_d     = host.host_wp;
                    sectid_d = host.host_sectid;
                    cnt_d    = '0;
                    if (host.host_err || (op_q == OP_SEEK) || (op_q == OP_READID)) begin
                        state_d = S_DONE;
                    end else if (op_q == OP_READ) begin
                        state_d = S_RDSTREAM;
                    end else begin
                        wphase_d = W_STROBE;
                        state_d  = S_WRSTREAM;
                    end
                end
            end

            S_RDSTREAM: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (host.host_rvalid) begin
                    din_d   = host.host_rdata;
                    clkin_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BYTE) state_d = S_DONE;
                end
            end

            S_WRSTREAM: begin
                if (timeout) begin
                    err_d    = 1'b1;
                    wvalid_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    case (wphase_q)
                        W_STROBE: wphase_d = W_CAPT;
                        W_CAPT: begin
                            wdata_d  = disk_data_out;
                            wvalid_d = 1'b1;
                            wphase_d = W_HOLD;
                        end
                        default: begin
                            if (host.host_wready) begin
                                wvalid_d = 1'b0;
                                cnt_d    = cnt_q + CNT_W'(1);
                                wphase_d = W_STROBE;
                                if (cnt_q == LAST_BYTE) state_d = S_WAITEND;
                            end
                        end
                    endcase
                end
            end

            S_WAITEND: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (host.host_ack) begin
                    err_d   = host.host_err;
                    wp_d    = host.host_wp;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                cr_sect_d = (op_q == OP_READID) ? sectid_q : sect_q;
                cr_head_d = head_q;
                cr_err_d  = err_q;
                cr_wp_d   = (op_q == OP_WRITE) && wp_q;
                if (op_q == OP_SEEK) begin
                    cr_seek_d = {drv_q, ~drv_q};
                    cr_done_d = 1'b0;
                end else begin
                    cr_seek_d = '0;
                    cr_done_d = 1'b1;
                end
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                if (disk_sr[23] && (disk_sr[31:24] == 8'h00)) begin
                    cr_done_d = 1'b0;
                    cr_err_d  = 1'b0;
                    cr_wp_d   = 1'b0;
                    cr_seek_d = '0;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wphase_q  <= W_STROBE;
            op_q      <= OP_SEEK;
            drv_q     <= 1'b0;
            cyl_q     <= '0;
            head_q    <= '0;
            sect_q    <= '0;
            err_q     <= 1'b0;
            wp_q      <= 1'b0;
            sectid_q  <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            din_q     <= '0;
            clkin_q   <= 1'b0;
            cr_sect_q <= '0;
            cr_head_q <= '0;
            cr_done_q <= 1'b0;
            cr_err_q  <= 1'b0;
            cr_wp_q   <= 1'b0;
            cr_seek_q <= '0;
        end else begin
            state_q   <= state_d;
            wphase_q  <= wphase_d;
            op_q      <= op_d;
            drv_q     <= drv_d;
            cyl_q     <= cyl_d;
            head_q    <= head_d;
            sect_q    <= sect_d;
            err_q     <= err_d;
            wp_q      <= wp_d;
            sectid_q  <= sectid_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            din_q     <= din_d;
            clkin_q   <= clkin_d;
            cr_sect_q <= cr_sect_d;
            cr_head_q <= cr_head_d;
            cr_done_q <= cr_done_d;
            cr_err_q  <= cr_err_d;
            cr_wp_q   <= cr_wp_d;
            cr_seek_q <= cr_seek_d;
        end
    end

    assign host.host_req    = (state_q == S_REQ) && !timeout;
    assign host.host_op     = op_q;
    assign host.host_drive  = drv_q;
    assign host.host_cyl    = cyl_q;
    assign host.host_head   = head_q;
    assign host.host_sect   = sect_q;
    assign host.host_rready = (state_q == S_RDSTREAM) && !timeout;
    assign host.host_wdata  = wdata_q;
    assign host.host_wvalid = wvalid_q && !timeout;

    assign disk_data_in     = din_q;
    assign disk_data_clkin  = clkin_q;
    assign disk_data_clkout = (state_q == S_WRSTREAM) && (wphase_q == W_STROBE) && !timeout;

    assign disk_cr = {cr_sect_q, 8'h00, cr_head_q, 1'b0, disk_present,
                      cr_done_q, cr_err_q, cr_wp_q, cr_seek_q};

endmodule
